// File: rtl/tone_detect_pkg.sv
// Shared types and sizing helpers for the streaming tone detector.
package tone_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REF  = 2'd1,
    ST_TONE = 2'd2
  } tone_state_e;

  // Accepted words per frame: total, reference bins, tone bins.
  function automatic int frame_len(input int n_ref, input int n_tone);
    return 1 + n_ref + n_tone;
  endfunction

  // Index width, never below 1 bit so single-bin configurations still elaborate.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int cnt_width(input int n_ref, input int n_tone);
    return idx_width((n_ref > n_tone) ? n_ref : n_tone);
  endfunction

endpackage

// File: rtl/tone_eval.sv
// Combinational qualification of one tone bin against frame total and reference maximum.
module tone_eval #(
  parameter int DW       = 31,
  parameter int RATIO_SH = 3
) (
  input  logic [DW-1:0] total,
  input  logic [DW-1:0] tone,
  input  logic [DW-1:0] maxref,
  output logic          qual
);

  localparam int XW = DW + RATIO_SH;

  logic [DW-1:0] w_diff;
  logic [XW-1:0] w_limit;

  // Energy outside the tone, clamped at zero, scaled in a widened word so it cannot wrap.
  assign w_diff  = (total > tone) ? (total - tone) : '0;
  assign w_limit = XW'(w_diff) << RATIO_SH;
  assign qual    = (XW'(tone) > w_limit) && (tone > maxref);

endmodule

// File: rtl/tone_detect_seq.sv
// Streaming tone detector: frame sequencer, strongest-tone tracking and hit debounce.
module tone_detect_seq
  import tone_detect_pkg::*;
#(
  parameter int DW       = 31,
  parameter int N_REF    = 6,
  parameter int N_TONE   = 6,
  parameter int RATIO_SH = 3,
  parameter int HOLD     = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_en,
  input  logic                           sof,
  input  logic [DW-1:0]                  din,
  output logic                           out_en,
  output logic                           is_large,
  output logic [idx_width(N_TONE)-1:0]   tone_idx,
  output logic                           detect,
  output logic                           frame_err
);

  localparam int IW = idx_width(N_TONE);
  localparam int CW = cnt_width(N_REF, N_TONE);
  localparam int HW = idx_width(HOLD + 1);

  tone_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_total;
  logic [DW-1:0] r_maxref;
  logic [DW-1:0] r_best_val;
  logic [IW-1:0] r_best_idx;
  logic          r_any;
  logic [HW-1:0] r_hits;
  logic          r_out_en;
  logic          r_is_large;
  logic [IW-1:0] r_tone_idx;
  logic          r_detect;
  logic          r_frame_err;

  logic          w_qual;
  logic          w_take;
  logic          w_any_nx;
  logic [IW-1:0] w_idx_nx;
  logic          w_last_ref;
  logic          w_last_tone;
  logic [HW-1:0] w_hits_inc;

  tone_eval #(
    .DW       (DW),
    .RATIO_SH (RATIO_SH)
  ) u_tone_eval (
    .total  (r_total),
    .tone   (din),
    .maxref (r_maxref),
    .qual   (w_qual)
  );

  // Strict '>' against the running best keeps the lowest index on ties.
  assign w_take      = w_qual && (!r_any || (din > r_best_val));
  assign w_any_nx    = r_any | w_qual;
  assign w_idx_nx    = w_take ? IW'(r_cnt) : r_best_idx;
  assign w_last_ref  = (r_cnt == CW'(N_REF - 1));
  assign w_last_tone = (r_cnt == CW'(N_TONE - 1));
  assign w_hits_inc  = (r_hits == HW'(HOLD)) ? r_hits : (r_hits + HW'(1));

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let later statements see updated state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_total     <= '0;
      r_maxref    <= '0;
      r_best_val  <= '0;
      r_best_idx  <= '0;
      r_any       <= 1'b0;
      r_hits      <= '0;
      r_out_en    <= 1'b0;
      r_is_large  <= 1'b0;
      r_tone_idx  <= '0;
      r_detect    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_out_en    <= 1'b0;
      r_frame_err <= 1'b0;
      if (in_en) begin
        if (sof) begin
          // A start word outside IDLE aborts the partial frame and begins a new one.
          r_frame_err <= (r_state != ST_IDLE);
          r_state     <= ST_REF;
          r_total     <= din;
          r_cnt       <= '0;
          r_maxref    <= '0;
          r_best_val  <= '0;
          r_best_idx  <= '0;
          r_any       <= 1'b0;
        end else begin
          case (r_state)
            ST_REF: begin
              if (din > r_maxref) r_maxref <= din;
              if (w_last_ref) begin
                r_cnt   <= '0;
                r_state <= ST_TONE;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
            ST_TONE: begin
              if (w_take) begin
                r_best_val <= din;
                r_best_idx <= w_idx_nx;
              end
              r_any <= w_any_nx;
              if (w_last_tone) begin
                r_cnt      <= '0;
                r_state    <= ST_IDLE;
                r_out_en   <= 1'b1;
                r_is_large <= w_any_nx;
                r_tone_idx <= w_any_nx ? w_idx_nx : '0;
                if (w_any_nx) begin
                  r_hits   <= w_hits_inc;
                  r_detect <= (w_hits_inc == HW'(HOLD));
                end else begin
                  r_hits   <= '0;
                  r_detect <= 1'b0;
                end
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign out_en    = r_out_en;
  assign is_large  = r_is_large;
  assign tone_idx  = r_tone_idx;
  assign detect    = r_detect;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_tone_detect_seq.sv
// Self-checking bench for tone_detect_seq against a frame-level reference model.
module tb_tone_detect_seq;

  localparam int DW       = 31;
  localparam int N_REF    = 6;
  localparam int N_TONE   = 6;
  localparam int RATIO_SH = 3;
  localparam int HOLD     = 4;
  localparam int IW       = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_en;
  logic          sof;
  logic [DW-1:0] din;
  logic          out_en;
  logic          is_large;
  logic [IW-1:0] tone_idx;
  logic          detect;
  logic          frame_err;

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  int ferr_cnt = 0;
  int pulses;

  longint unsigned f_t;
  longint unsigned f_r [N_REF];
  longint unsigned f_s [N_TONE];
  bit              exp_large;
  int              exp_idx;
  bit              exp_detect;
  int              hits_m = 0;

  always #5 clk = ~clk;

  tone_detect_seq #(
    .DW(DW), .N_REF(N_REF), .N_TONE(N_TONE), .RATIO_SH(RATIO_SH), .HOLD(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_en(in_en), .sof(sof), .din(din),
    .out_en(out_en), .is_large(is_large), .tone_idx(tone_idx),
    .detect(detect), .frame_err(frame_err)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // All sampling and driving happens on the falling edge, away from the active edge.
  task automatic tick();
    @(negedge clk);
    if (out_en === 1'b1) out_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
  endtask

  task automatic idle();
    tick();
    in_en = 1'b0;
    sof   = 1'b0;
  endtask

  task automatic send_word(input bit s, input longint unsigned d, input int gap);
    repeat (gap) idle();
    tick();
    in_en = 1'b1;
    sof   = s;
    din   = DW'(d);
  endtask

  function automatic int rgap(input int max_gap);
    return (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
  endfunction

  task automatic fill(input longint unsigned t, input longint unsigned rv);
    f_t = t;
    for (int i = 0; i < N_REF; i++) f_r[i] = rv;
    for (int i = 0; i < N_TONE; i++) f_s[i] = 0;
  endtask

  // Frame-level rules: qualify each tone, keep the largest (lowest index on ties), debounce.
  task automatic compute_model();
    longint unsigned maxr, best, d;
    bit found;
    maxr = 0; best = 0; found = 0; exp_idx = 0;
    for (int i = 0; i < N_REF; i++) if (f_r[i] > maxr) maxr = f_r[i];
    for (int k = 0; k < N_TONE; k++) begin
      d = (f_t > f_s[k]) ? f_t - f_s[k] : 0;
      if (f_s[k] > (d * (64'd1 << RATIO_SH)) && f_s[k] > maxr && (!found || f_s[k] > best)) begin
        found = 1; best = f_s[k]; exp_idx = k;
      end
    end
    exp_large = found;
    hits_m = found ? ((hits_m < HOLD) ? hits_m + 1 : HOLD) : 0;
    exp_detect = (hits_m == HOLD);
  endtask

  // Drives one frame (optionally without its total word) and samples the cycle after the last tone.
  task automatic run_frame(input int max_gap, input bit skip_t);
    int o0;
    o0 = out_cnt;
    if (!skip_t) send_word(1'b1, f_t, rgap(max_gap));
    for (int i = 0; i < N_REF; i++) send_word(1'b0, f_r[i], rgap(max_gap));
    for (int i = 0; i < N_TONE; i++) send_word(1'b0, f_s[i], rgap(max_gap));
    idle();
    compute_model();
    pulses = out_cnt - o0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_en = 1'b0; sof = 1'b0; din = '0;
    tick(); tick();
    rst_n = 1'b1;
    hits_m = 0;
    checks++;
    if ({out_en, is_large, tone_idx, detect, frame_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0", {out_en, is_large, tone_idx, detect, frame_err});
    end
  endtask

  task automatic test_basic_hit();
    fill(1000, 10);
    f_s[2] = 950;
    run_frame(0, 1'b0);
    checks++;
    if (pulses !== 1 || {out_en, is_large, tone_idx, detect} !== {1'b1, exp_large, IW'(exp_idx), exp_detect}) begin
      errors++;
      $display("FAIL basic_hit: pulses=%0d out=%b expected pulses=1 out=%b", pulses,
               {out_en, is_large, tone_idx, detect}, {1'b1, exp_large, IW'(exp_idx), exp_detect});
    end
    idle();
    checks++;
    if (out_en !== 1'b0 || is_large !== exp_large || tone_idx !== IW'(exp_idx)) begin
      errors++;
      $display("FAIL basic_hold: out_en=%b is_large=%b idx=%0d expected 0/%b/%0d", out_en, is_large,
               tone_idx, exp_large, exp_idx);
    end
  endtask

  task automatic test_ratio_miss();
    fill(1000, 10);
    f_s[2] = 800;
    run_frame(0, 1'b0);
    checks++;
    if (pulses !== 1 || {out_en, is_large, tone_idx, detect} !== {1'b1, exp_large, IW'(exp_idx), exp_detect}) begin
      errors++;
      $display("FAIL ratio_miss: pulses=%0d out=%b expected pulses=1 out=%b", pulses,
               {out_en, is_large, tone_idx, detect}, {1'b1, exp_large, IW'(exp_idx), exp_detect});
    end
  endtask

  task automatic test_clamp_strict();
    fill(100, 5);
    f_s[4] = 150;
    run_frame(0, 1'b0);
    checks++;
    if ({out_en, is_large, tone_idx} !== {1'b1, exp_large, IW'(exp_idx)}) begin
      errors++;
      $display("FAIL clamp_hit: out=%b expected %b", {out_en, is_large, tone_idx}, {1'b1, exp_large, IW'(exp_idx)});
    end
    f_r[3] = 150;
    run_frame(0, 1'b0);
    checks++;
    if ({out_en, is_large, tone_idx} !== {1'b1, exp_large, IW'(exp_idx)}) begin
      errors++;
      $display("FAIL strict_ref: out=%b expected %b", {out_en, is_large, tone_idx}, {1'b1, exp_large, IW'(exp_idx)});
    end
  endtask

  task automatic test_wide_values();
    // Scaled difference would wrap to 0 in DW bits; a wide compare must reject it.
    fill(64'h2FFF_FFFF, 1);
    f_s[1] = 64'h1FFF_FFFF;
    run_frame(1, 1'b0);
    checks++;
    if ({is_large, tone_idx} !== {exp_large, IW'(exp_idx)}) begin
      errors++;
      $display("FAIL no_wrap: out=%b expected %b", {is_large, tone_idx}, {exp_large, IW'(exp_idx)});
    end
    f_s[3] = 64'h2FFF_FFF0;
    f_s[5] = 64'h2FFF_FFF0;
    run_frame(1, 1'b0);
    checks++;
    if ({is_large, tone_idx} !== {exp_large, IW'(exp_idx)}) begin
      errors++;
      $display("FAIL tie_low_index: out=%b expected %b", {is_large, tone_idx}, {exp_large, IW'(exp_idx)});
    end
  endtask

  task automatic random_hit_frame();
    int k;
    fill($urandom_range(0, 1000), $urandom_range(0, 100));
    for (int i = 0; i < N_TONE; i++) f_s[i] = $urandom_range(0, 100);
    k = $urandom_range(0, N_TONE - 1);
    f_s[k] = f_t + 200 + $urandom_range(0, 50);
  endtask

  task automatic test_debounce();
    fill(1000, 10);
    run_frame(0, 1'b0);
    for (int f = 0; f < 5; f++) begin
      if (f < 4) random_hit_frame();
      else fill(1000, 10);
      run_frame(3, 1'b0);
      checks++;
      if (pulses !== 1 || {is_large, tone_idx, detect} !== {exp_large, IW'(exp_idx), exp_detect}) begin
        errors++;
        $display("FAIL debounce_f%0d: pulses=%0d out=%b expected pulses=1 out=%b", f, pulses,
                 {is_large, tone_idx, detect}, {exp_large, IW'(exp_idx), exp_detect});
      end
    end
  endtask

  task automatic test_abort();
    int f0, o0;
    fill(1000, 10);
    run_frame(0, 1'b0);
    for (int f = 0; f < 2; f++) begin
      random_hit_frame();
      run_frame(0, 1'b0);
    end
    f0 = ferr_cnt; o0 = out_cnt;
    send_word(1'b1, 500, 0);
    send_word(1'b0, 7, 0);
    send_word(1'b0, 7, 0);
    random_hit_frame();
    send_word(1'b1, f_t, 0);
    idle();
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL abort_pulse: frame_err=%b expected 1", frame_err);
    end
    run_frame(0, 1'b1);
    checks++;
    if (ferr_cnt - f0 !== 1 || out_cnt - o0 !== 1 || {is_large, detect} !== {exp_large, exp_detect}) begin
      errors++;
      $display("FAIL abort_ref: ferr=%0d outs=%0d out=%b expected 1/1/%b", ferr_cnt - f0, out_cnt - o0,
               {is_large, detect}, {exp_large, exp_detect});
    end
    f0 = ferr_cnt; o0 = out_cnt;
    send_word(1'b1, 300, 0);
    for (int i = 0; i < N_REF + N_TONE - 1; i++) send_word(1'b0, 3, 1);
    random_hit_frame();
    run_frame(0, 1'b0);
    checks++;
    if (ferr_cnt - f0 !== 1 || out_cnt - o0 !== 1 || {is_large, tone_idx, detect} !== {exp_large, IW'(exp_idx), exp_detect}) begin
      errors++;
      $display("FAIL abort_last: ferr=%0d outs=%0d out=%b expected 1/1/%b", ferr_cnt - f0, out_cnt - o0,
               {is_large, tone_idx, detect}, {exp_large, IW'(exp_idx), exp_detect});
    end
  endtask

  task automatic test_reset_midframe();
    int o0;
    random_hit_frame();
    run_frame(0, 1'b0);
    o0 = out_cnt;
    send_word(1'b1, f_t, 0);
    for (int i = 0; i < N_REF; i++) send_word(1'b0, f_r[i], 0);
    send_word(1'b0, f_s[0], 0);
    send_word(1'b0, f_s[1], 0);
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    hits_m = 0;
    checks++;
    if ({out_en, is_large, tone_idx, detect, frame_err} !== '0 || out_cnt !== o0) begin
      errors++;
      $display("FAIL mid_reset: out=%b outs=%0d expected 0 and 0", {out_en, is_large, tone_idx, detect, frame_err},
               out_cnt - o0);
    end
    for (int i = 2; i < N_TONE; i++) send_word(1'b0, f_s[i], 0);
    idle();
    checks++;
    if (out_cnt !== o0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL orphan_words: outs=%0d frame_err=%b expected 0/0", out_cnt - o0, frame_err);
    end
    for (int f = 0; f < 4; f++) begin
      random_hit_frame();
      run_frame(2, 1'b0);
      checks++;
      if ({out_en, is_large, detect} !== {1'b1, exp_large, exp_detect}) begin
        errors++;
        $display("FAIL refill_f%0d: out=%b expected %b", f, {out_en, is_large, detect}, {1'b1, exp_large, exp_detect});
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      fill($urandom_range(0, 200), 0);
      for (int i = 0; i < N_REF; i++) f_r[i] = $urandom_range(0, 60);
      for (int i = 0; i < N_TONE; i++) f_s[i] = $urandom_range(150, 230);
      if ($urandom_range(0, 3) == 0) f_s[$urandom_range(0, N_TONE - 1)] = 0;
      run_frame((f % 2 == 0) ? 0 : 2, 1'b0);
      checks++;
      if (pulses !== 1 || {out_en, is_large, tone_idx, detect} !== {1'b1, exp_large, IW'(exp_idx), exp_detect}) begin
        errors++;
        $display("FAIL random_f%0d: pulses=%0d out=%b expected pulses=1 out=%b", f, pulses,
                 {out_en, is_large, tone_idx, detect}, {1'b1, exp_large, IW'(exp_idx), exp_detect});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_ratio_miss();
    test_clamp_strict();
    test_wide_values();
    test_debounce();
    test_abort();
    test_reset_midframe();
    test_random();
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
